// File: rtl/fb_pkg.sv
// Shared framebuffer scheduler definitions: FSM encodings, default widths
// and the 640x480 active-area geometry.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } fb_state_e;

  localparam int FB_ADDR_W   = 19;
  localparam int FB_DATA_W   = 8;
  localparam int FB_H_ACTIVE = 640;
  localparam int FB_V_ACTIVE = 480;
  localparam int FB_PIXELS   = FB_H_ACTIVE * FB_V_ACTIVE;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is requester A, bit 1 is requester B;
// the pointer only moves when a grant is actually taken.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // ptr_q = 0 favours A, 1 favours B
  logic ptr_q, ptr_d;

  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) o_grant = ptr_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (i_advance && (|o_grant)) ptr_d = o_grant[0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: arbitrates two requesters into a per-frame
// write budget. Define FB_SCHED_BLANK_ONLY_EN to restrict writes to blanking.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int MAX_WR = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_blanking,
  input  logic              i_animate,
  input  logic              i_a_valid,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_data,
  output logic              o_a_ready,
  input  logic              i_b_valid,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_data,
  output logic              o_b_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_wr,
  output logic [1:0]        o_state
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WR);

  fb_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, frame_wr_q, frame_wr_d, cnt_inc;
  logic              we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              gate, frame_ev, slot_open, xfer;
  logic [1:0]        grant;

`ifdef FB_SCHED_BLANK_ONLY_EN
  assign gate = i_blanking;
`else
  assign gate = i_blanking | 1'b1;
`endif

  assign frame_ev  = i_animate & i_pix_stb;
  assign slot_open = (state_q == ST_RUN) & i_pix_stb & gate;

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   ({i_b_valid, i_a_valid}),
    .i_advance (slot_open),
    .o_grant   (grant)
  );

  assign o_a_ready = slot_open & grant[0];
  assign o_b_ready = slot_open & grant[1];
  assign xfer      = o_a_ready | o_b_ready;
  assign cnt_inc   = cnt_q + {15'd0, xfer};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    frame_wr_d = frame_wr_q;
    done_d     = 1'b0;
    we_d       = xfer;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (xfer) begin
      waddr_d = o_a_ready ? i_a_addr : i_b_addr;
      wdata_d = o_a_ready ? i_a_data : i_b_data;
    end
    // A frame event wins over reaching the budget: the count restarts anyway
    if (frame_ev) begin
      cnt_d   = 16'd0;
      state_d = ST_RUN;
      if (state_q != ST_SYNC) begin
        frame_wr_d = cnt_inc;
        done_d     = 1'b1;
      end
    end else if (state_q == ST_RUN && cnt_inc == MAX_CNT) begin
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_SYNC;
      cnt_q      <= 16'd0;
      frame_wr_q <= 16'd0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_wr_q <= frame_wr_d;
      done_q     <= done_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign o_we         = we_q;
  assign o_waddr      = waddr_q;
  assign o_wdata      = wdata_q;
  assign o_frame_done = done_q;
  assign o_frame_wr   = frame_wr_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched: a driver feeds a frame-budget model
// that queues expected writes/frame reports; a monitor checks them each clock.
module tb_fb_write_sched;

  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_stb = 0, blanking = 0, animate = 0;
  logic          a_valid = 0, b_valid = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, we, frame_done;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [15:0]   frame_wr;
  logic [1:0]    state;

  fb_write_sched #(.ADDR_W(AW), .DATA_W(DW), .MAX_WR(MAXW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_blanking(blanking),
    .i_animate(animate),
    .i_a_valid(a_valid), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_ready(b_ready),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_frame_done(frame_done), .o_frame_wr(frame_wr), .o_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  tests = 0, fails = 0;
  wr_t wq[$];
  int  fq[$];
  bit  mon_en = 0;

  // Reference model: "synced" once a frame event has been seen, a count of
  // grants in this frame, and which requester wins a tie next.
  bit            synced = 0;
  int            cnt = 0;
  bit            ptr_b = 0;
  int            exp_state = 0;
  int            exp_fw = 0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    synced = 0; cnt = 0; ptr_b = 0; exp_state = 0; exp_fw = 0;
    last_a = '0; last_d = '0;
    wq.delete(); fq.delete();
  endtask

  // One clock of stimulus; expectations derived from the model before the edge.
  task automatic cyc(input bit stb, input bit anim, input bit blank, input bit av, input bit bv);
    bit gate, slot, ga, gb, fe;
    wr_t w;
    @(negedge clk);
    pix_stb = stb; animate = anim; blanking = blank;
    a_valid = av; b_valid = bv;
    a_addr = AW'($urandom_range(0, 307199)); a_data = DW'($urandom);
    b_addr = AW'($urandom_range(0, 307199)); b_data = DW'($urandom);
    #1;
    fe = anim && stb;
`ifdef FB_SCHED_BLANK_ONLY_EN
    gate = blank;
`else
    gate = 1'b1;
`endif
    slot = synced && (cnt < MAXW) && stb && gate;
    ga = 0; gb = 0;
    if (slot) begin
      if (av && bv) begin
        ga = !ptr_b; gb = ptr_b;
      end else begin
        ga = av; gb = bv;
      end
    end
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    if (ga || gb) begin
      w.a = ga ? a_addr : b_addr;
      w.d = ga ? a_data : b_data;
      wq.push_back(w);
      ptr_b = ga;
      cnt++;
    end
    if (fe) begin
      if (synced) begin
        fq.push_back(cnt);
        exp_fw = cnt;
      end
      cnt = 0;
      synced = 1;
    end
    exp_state = !synced ? 0 : (cnt == MAXW ? 2 : 1);
  endtask

  always @(posedge clk) begin
    wr_t w;
    int  fw;
    #1;
    if (mon_en) begin
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("we", we, 1);
        chk("waddr", waddr, w.a);
        chk("wdata", wdata, w.d);
        last_a = w.a; last_d = w.d;
      end else begin
        chk("we_idle", we, 0);
        chk("waddr_hold", waddr, last_a);
        chk("wdata_hold", wdata, last_d);
      end
      if (fq.size() > 0) begin
        fw = fq.pop_front();
        chk("frame_done", frame_done, 1);
        chk("frame_wr", frame_wr, fw);
      end else begin
        chk("frame_done_idle", frame_done, 0);
        chk("frame_wr_hold", frame_wr, exp_fw);
      end
      chk("state", state, exp_state);
    end
  end

  initial begin
    bit found;
    // Reset state with live requests present
    a_valid = 1; b_valid = 1; pix_stb = 1; animate = 1; blanking = 1;
    #12;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_frame_wr", frame_wr, 0);
    chk("rst_state", state, 0);
    animate = 0;
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;

    // No frame event yet: never granted
    repeat (20) cyc(1, 0, 1, 1, 0);
    // First frame event in SYNC: no frame_done
    cyc(1, 1, 1, 0, 0);
    // Both valid, strobe every other clock: alternating grants up to budget
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 1, 1, 1);
      cyc(0, 0, 1, 1, 1);
    end
    cyc(1, 0, 1, 1, 1);
    cyc(1, 1, 1, 0, 0);
    // Grant coincident with frame event at count 5 -> reports 6
    repeat (5) cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 0);
    // Budget exhaustion with A continuously valid, then next frame
    repeat (12) cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 0, 0);
    // Blanking low then high
    repeat (4) cyc(1, 0, 0, 1, 1);
    repeat (4) cyc(1, 0, 1, 1, 1);
    cyc(1, 1, 1, 0, 0);

    // Asynchronous reset while a write is on the port
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1, 0, 1, 1, 0);
      found = (wq.size() > 0);
    end
    chk("mid_grant_found", {31'd0, found}, 1);
    @(posedge clk);
    #2;
    chk("we_before_rst", we, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("we_async_rst", we, 0);
    chk("state_async_rst", state, 0);
    chk("waddr_async_rst", waddr, 0);
    repeat (2) cyc(1, 0, 1, 1, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (6) cyc(1, 0, 1, 1, 1);
    cyc(1, 1, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    repeat (3) cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("wq_drained", wq.size(), 0);
    chk("fq_drained", fq.size(), 0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
